// File: rtl/md_unit_pkg.sv
// -----------------------------------------------------------------------------
// md_unit_pkg
// Shared definitions for the multiply/divide unit and the controller that
// drives it: operation codes, unit FSM states and default latencies.
// -----------------------------------------------------------------------------
package md_unit_pkg;

  // Operation codes carried on md_op. MD_RSVD behaves as a NOP.
  typedef enum logic [2:0] {
    MD_NOP   = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6,
    MD_RSVD  = 3'd7
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

  localparam int MD_MULT_CYCLES_DEF = 5;
  localparam int MD_DIV_CYCLES_DEF  = 10;

endpackage

// File: rtl/md_unit_if.sv
// -----------------------------------------------------------------------------
// md_unit_if
// Bundle between the datapath controller (master) and md_unit (slave).
//   start  : qualifies md_op for one cycle
//   md_op  : operation code (md_op_e)
//   md_a   : operand A (rs read data)
//   md_b   : operand B (rt read data)
//   busy   : multi-cycle operation in progress
//   hi, lo : architectural HI/LO registers
// -----------------------------------------------------------------------------
interface md_unit_if;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] md_a;
  logic [31:0] md_b;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, md_op, md_a, md_b,
    input  busy, hi, lo
  );

  modport slave (
    input  start, md_op, md_a, md_b,
    output busy, hi, lo
  );
endinterface

// File: rtl/md_unit.sv
// -----------------------------------------------------------------------------
// md_unit
// MIPS multiply/divide unit. MULT/MULTU/DIV/DIVU results are computed from the
// operands present at acceptance, parked in pending registers, and committed
// to HI/LO when a fixed-latency countdown expires. MTHI/MTLO write directly.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset, clears all state
//   md    : md_unit_if.slave (start/md_op/md_a/md_b in, busy/hi/lo out)
// -----------------------------------------------------------------------------
module md_unit
  import md_unit_pkg::*;
#(
  parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       reset,
  md_unit_if.slave   md
);

  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam logic [CNT_W-1:0] MULT_N = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_N  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_1  = CNT_W'(1);

  // Arithmetic helpers. Everything is done in 64 bits so the signed
  // 0x80000000 / -1 case yields quotient 0x80000000 without overflowing.
  function automatic logic [63:0] mul_s(input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] a64;
    logic signed [63:0] b64;
    logic signed [63:0] p64;
    a64 = {{32{a[31]}}, a};
    b64 = {{32{b[31]}}, b};
    p64 = a64 * b64;
    return p64;
  endfunction

  function automatic logic [63:0] mul_u(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] a64;
    logic [63:0] b64;
    a64 = {32'd0, a};
    b64 = {32'd0, b};
    return a64 * b64;
  endfunction

  // Returns {remainder, quotient}; remainder takes the dividend's sign.
  function automatic logic [63:0] div_s(input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] a64;
    logic signed [63:0] b64;
    logic signed [63:0] q64;
    logic signed [63:0] r64;
    a64 = {{32{a[31]}}, a};
    b64 = {{32{b[31]}}, b};
    if (b == 32'd0) begin
      q64 = '0;
      r64 = '0;
    end else begin
      q64 = a64 / b64;
      r64 = a64 % b64;
    end
    return {r64[31:0], q64[31:0]};
  endfunction

  function automatic logic [63:0] div_u(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q;
    logic [31:0] r;
    if (b == 32'd0) begin
      q = '0;
      r = '0;
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  md_op_e           op;
  md_state_e        state;
  logic [CNT_W-1:0] cnt;
  logic             busy_q;
  logic [31:0]      hi_q;
  logic [31:0]      lo_q;
  logic [31:0]      pend_hi;
  logic [31:0]      pend_lo;
  logic             pend_wr;
  logic [63:0]      res;
  logic             res_wr;

  assign op = md_op_e'(md.md_op);

  // Result for the operation currently offered; res_wr drops for a zero
  // divisor so HI/LO survive the (full-length) divide untouched.
  always_comb begin
    res    = '0;
    res_wr = 1'b0;
    case (op)
      MD_MULT:  begin res = mul_s(md.md_a, md.md_b); res_wr = 1'b1; end
      MD_MULTU: begin res = mul_u(md.md_a, md.md_b); res_wr = 1'b1; end
      MD_DIV:   begin res = div_s(md.md_a, md.md_b); res_wr = (md.md_b != 32'd0); end
      MD_DIVU:  begin res = div_u(md.md_a, md.md_b); res_wr = (md.md_b != 32'd0); end
      default:  begin res = '0; res_wr = 1'b0; end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      busy_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
      pend_wr <= 1'b0;
    end else begin
      case (state)
        // Accept stage: operands captured into pending registers.
        ST_IDLE: begin
          if (md.start) begin
            case (op)
              MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
                pend_hi <= res[63:32];
                pend_lo <= res[31:0];
                pend_wr <= res_wr;
                cnt     <= (op == MD_DIV || op == MD_DIVU) ? DIV_N : MULT_N;
                state   <= ST_RUN;
                busy_q  <= 1'b1;
              end
              MD_MTHI: hi_q <= md.md_a;
              MD_MTLO: lo_q <= md.md_a;
              default: ;
            endcase
          end
        end
        // Countdown stage: commit on the 1 -> 0 edge; start is ignored here.
        ST_RUN: begin
          cnt <= cnt - CNT_1;
          if (cnt == CNT_1) begin
            state  <= ST_IDLE;
            busy_q <= 1'b0;
            if (pend_wr) begin
              hi_q <= pend_hi;
              lo_q <= pend_lo;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign md.busy = busy_q;
  assign md.hi   = hi_q;
  assign md.lo   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// -----------------------------------------------------------------------------
// tb_md_unit
// Directed bench for md_unit: a vector table of operations with hand-computed
// HI/LO and busy lengths, plus sequences for busy-start, MTHI/MTLO
// back-to-back, zero-bubble restart and asynchronous reset mid-operation.
// -----------------------------------------------------------------------------
module tb_md_unit;
  import md_unit_pkg::*;

  logic clk;
  logic reset_n;
  int   compared;
  int   failed;

  md_unit_if bus();

  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset_n),
    .md    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          n;
    logic [31:0] ehi;
    logic [31:0] elo;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Called at a negedge with busy already high; counts busy cycles (bounded).
  task automatic count_busy(input string nm, input logic [31:0] hold_hi,
                            input logic [31:0] hold_lo, output int n);
    n = 0;
    while (bus.busy === 1'b1 && n < 40) begin
      chk({nm, "_hold_hi"}, bus.hi, hold_hi);
      chk({nm, "_hold_lo"}, bus.lo, hold_lo);
      n++;
      @(negedge clk);
    end
  endtask

  task automatic drive(input logic st, input logic [2:0] op,
                       input logic [31:0] a, input logic [31:0] b);
    bus.start = st;
    bus.md_op = op;
    bus.md_a  = a;
    bus.md_b  = b;
  endtask

  logic [31:0] prev_hi;
  logic [31:0] prev_lo;
  int          n;

  initial begin
    compared = 0;
    failed   = 0;
    vecs[0]  = '{MD_MULT,  32'hFFFFFFFE, 32'h00000003,  5, 32'hFFFFFFFF, 32'hFFFFFFFA};
    vecs[1]  = '{MD_MULTU, 32'hFFFFFFFE, 32'h00000003,  5, 32'h00000002, 32'hFFFFFFFA};
    vecs[2]  = '{MD_DIV,   32'hFFFFFFF9, 32'h00000002, 10, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3]  = '{MD_DIVU,  32'h00000007, 32'h00000002, 10, 32'h00000001, 32'h00000003};
    vecs[4]  = '{MD_DIV,   32'h80000000, 32'hFFFFFFFF, 10, 32'h00000000, 32'h80000000};
    vecs[5]  = '{MD_MTHI,  32'h00000011, 32'h0000AAAA,  0, 32'h00000011, 32'h80000000};
    vecs[6]  = '{MD_MTLO,  32'h00000022, 32'h0000BBBB,  0, 32'h00000011, 32'h00000022};
    vecs[7]  = '{MD_DIVU,  32'h00000005, 32'h00000000, 10, 32'h00000011, 32'h00000022};
    vecs[8]  = '{MD_DIV,   32'hFFFFFFF0, 32'h00000000, 10, 32'h00000011, 32'h00000022};
    vecs[9]  = '{MD_NOP,   32'h12345678, 32'h00000001,  0, 32'h00000011, 32'h00000022};
    vecs[10] = '{MD_RSVD,  32'h12345678, 32'h00000001,  0, 32'h00000011, 32'h00000022};
    vecs[11] = '{MD_MULT,  32'h80000000, 32'h80000000,  5, 32'h40000000, 32'h00000000};
    vecs[12] = '{MD_DIV,   32'h80000000, 32'h00000003, 10, 32'hFFFFFFFE, 32'hD5555556};
    vecs[13] = '{MD_DIV,   32'h00000007, 32'hFFFFFFFE, 10, 32'h00000001, 32'hFFFFFFFD};
    vecs[14] = '{MD_DIVU,  32'hFFFFFFFF, 32'h00000010, 10, 32'h0000000F, 32'h0FFFFFFF};

    // Reset state
    reset_n = 1'b0;
    drive(1'b0, MD_NOP, 32'd0, 32'd0);
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_hi", bus.hi, 32'd0);
    chk("rst_lo", bus.lo, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Vector table; operands are scrambled after acceptance
    prev_hi = 32'd0;
    prev_lo = 32'd0;
    for (int i = 0; i < 15; i++) begin
      drive(1'b1, vecs[i].op, vecs[i].a, vecs[i].b);
      @(negedge clk);
      drive(1'b0, MD_MULT, ~vecs[i].a, ~vecs[i].b);
      count_busy($sformatf("v%0d", i), prev_hi, prev_lo, n);
      chk($sformatf("v%0d_busy_cycles", i), n, vecs[i].n);
      chk($sformatf("v%0d_hi", i), bus.hi, vecs[i].ehi);
      chk($sformatf("v%0d_lo", i), bus.lo, vecs[i].elo);
      prev_hi = vecs[i].ehi;
      prev_lo = vecs[i].elo;
    end

    // MTHI then MTLO on consecutive cycles
    drive(1'b1, MD_MTHI, 32'hDEADBEEF, 32'd0);
    @(negedge clk);
    chk("mthi_busy", {31'd0, bus.busy}, 32'd0);
    chk("mthi_hi", bus.hi, 32'hDEADBEEF);
    drive(1'b1, MD_MTLO, 32'h12345678, 32'd0);
    @(negedge clk);
    drive(1'b0, MD_NOP, 32'd0, 32'd0);
    chk("mtlo_busy", {31'd0, bus.busy}, 32'd0);
    chk("mtlo_hi", bus.hi, 32'hDEADBEEF);
    chk("mtlo_lo", bus.lo, 32'h12345678);

    // Back-to-back MULT with no bubble after completion
    drive(1'b1, MD_MULT, 32'd6, 32'd7);
    @(negedge clk);
    drive(1'b0, MD_NOP, 32'd0, 32'd0);
    count_busy("b2b1", 32'hDEADBEEF, 32'h12345678, n);
    chk("b2b1_busy_cycles", n, 5);
    chk("b2b1_hi", bus.hi, 32'd0);
    chk("b2b1_lo", bus.lo, 32'd42);
    drive(1'b1, MD_MULTU, 32'h00010000, 32'h00010000);
    @(negedge clk);
    drive(1'b0, MD_NOP, 32'd0, 32'd0);
    chk("b2b2_accepted", {31'd0, bus.busy}, 32'd1);
    count_busy("b2b2", 32'd0, 32'd42, n);
    chk("b2b2_busy_cycles", n, 5);
    chk("b2b2_hi", bus.hi, 32'd1);
    chk("b2b2_lo", bus.lo, 32'd0);

    // MULT offered while a DIVU runs must be ignored
    drive(1'b1, MD_DIVU, 32'd100, 32'd7);
    @(negedge clk);
    drive(1'b0, MD_NOP, 32'd0, 32'd0);
    n = 0;
    while (bus.busy === 1'b1 && n < 40) begin
      if (n == 3) drive(1'b1, MD_MULT, 32'd3, 32'd3);
      else        drive(1'b0, MD_NOP, 32'd0, 32'd0);
      n++;
      @(negedge clk);
    end
    drive(1'b0, MD_NOP, 32'd0, 32'd0);
    chk("busy_start_cycles", n, 10);
    chk("busy_start_hi", bus.hi, 32'd2);
    chk("busy_start_lo", bus.lo, 32'd14);
    @(negedge clk);
    chk("busy_start_idle", {31'd0, bus.busy}, 32'd0);
    chk("busy_start_hi2", bus.hi, 32'd2);

    // Asynchronous reset during cycle 2 of a MULT
    drive(1'b1, MD_MULT, 32'd5, 32'd7);
    @(negedge clk);
    drive(1'b0, MD_NOP, 32'd0, 32'd0);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_busy", {31'd0, bus.busy}, 32'd0);
    chk("arst_hi", bus.hi, 32'd0);
    chk("arst_lo", bus.lo, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("arst_after_busy", {31'd0, bus.busy}, 32'd0);
    chk("arst_after_hi", bus.hi, 32'd0);
    chk("arst_after_lo", bus.lo, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
